fifo_read_ctrl: RTL and testbench



---
 rtl/fifo_read_ctrl_pkg.sv | 21 ++
 rtl/fifo_ptr_occupancy.sv | 29 ++
 rtl/fifo_read_ctrl.sv | 107 ++++++++++
 tb/tb_fifo_read_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_read_ctrl_pkg.sv
// +-------------------------------------------------------------------------+
// | fifo_read_ctrl_pkg : shared constants for the profiling FIFO controllers |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

package fifo_read_ctrl_pkg;

  localparam int STALL_CNT_WIDTH = 32;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ptr_occupancy.sv
// +-------------------------------------------------------------------------+
// | fifo_ptr_occupancy : pending-sample count and empty flag from pointers  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module fifo_ptr_occupancy
  import fifo_read_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic [ADDR_WIDTH:0] wr_ptr,
  input  logic [ADDR_WIDTH:0] rd_ptr,
  output logic [ADDR_WIDTH:0] pending,
  output logic                is_empty
);

  localparam int PTR_W = ptr_width(ADDR_WIDTH);

  logic [PTR_W-1:0] diff;

  // Modular subtraction: the wrap bit disambiguates full from empty.
  assign diff     = wr_ptr - rd_ptr;
  assign pending  = diff;
  assign is_empty = (diff == '0);

endmodule

`default_nettype wire

// File: rtl/fifo_read_ctrl.sv
// +-------------------------------------------------------------------------+
// | fifo_read_ctrl : read-side controller of the profiling-counter FIFO,    |
// | streaming RAM samples out on a registered valid/ready interface.        |
// | Optional stall counter: FIFO_READ_CTRL_STALL_CNT_EN                     |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module fifo_read_ctrl
  import fifo_read_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   wrPtr,
  output logic [ADDR_WIDTH:0]   rdPtr,
  output logic [ADDR_WIDTH-1:0] ramAddress,
  input  logic [DATA_WIDTH-1:0] ramReadData,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic                  empty,
`ifdef FIFO_READ_CTRL_STALL_CNT_EN
  output logic [STALL_CNT_WIDTH-1:0] stallCount,
`endif
  output logic [ADDR_WIDTH:0]   level
);

  localparam int PTR_W = ptr_width(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH+1:0] LEVEL_MAX = {2'b01, {ADDR_WIDTH{1'b0}}};

  logic [PTR_W-1:0]      pending;
  logic                  ram_empty;
  logic                  load;
  logic [0:0]            state;
  logic [0:0]            state_next;
  logic [ADDR_WIDTH+1:0] level_sum;

  fifo_ptr_occupancy #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_occupancy (
    .wr_ptr  (wrPtr),
    .rd_ptr  (rdPtr),
    .pending (pending),
    .is_empty(ram_empty)
  );

  assign ramAddress = rdPtr[ADDR_WIDTH-1:0];
  assign load       = !flush && !ram_empty && (!outValid || outReady);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ST_IDLE;
    end else if (load) begin
      state_next = ST_HOLD;
    end else if (state == ST_HOLD && outReady) begin
      state_next = ST_IDLE;
    end
  end

  always_comb begin
    outValid = (state == ST_HOLD);
  end

  // Flush snaps to the pre-edge write pointer so a same-edge write survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr   <= '0;
      outData <= '0;
    end else if (flush) begin
      rdPtr   <= wrPtr;
    end else if (load) begin
      rdPtr   <= rdPtr + 1'b1;
      outData <= ramReadData;
    end
  end

  assign empty     = ram_empty && !outValid;
  assign level_sum = {1'b0, pending} + {{(ADDR_WIDTH+1){1'b0}}, outValid};
  assign level     = (level_sum > LEVEL_MAX) ? LEVEL_MAX[ADDR_WIDTH:0]
                                             : level_sum[ADDR_WIDTH:0];

`ifdef FIFO_READ_CTRL_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCount <= '0;
    end else if (outValid && !outReady && (stallCount != {STALL_CNT_WIDTH{1'b1}})) begin
      stallCount <= stallCount + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_read_ctrl.sv
// +-------------------------------------------------------------------------+
// | tb_fifo_read_ctrl : directed table-driven bench for fifo_read_ctrl      |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_fifo_read_ctrl;

  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW:0]   wrPtr;
  logic [AW:0]   rdPtr;
  logic [AW-1:0] ramAddress;
  logic [DW-1:0] ramReadData;
  logic          flush;
  logic [DW-1:0] outData;
  logic          outValid;
  logic          outReady;
  logic          empty;
  logic [AW:0]   level;
`ifdef FIFO_READ_CTRL_STALL_CNT_EN
  logic [31:0]   stallCount;
`endif

  logic [DW-1:0] mem [16];
  logic [AW:0]   tb_pending;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign ramReadData = mem[ramAddress];
  assign tb_pending  = wrPtr - rdPtr;

  fifo_read_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wrPtr      (wrPtr),
    .rdPtr      (rdPtr),
    .ramAddress (ramAddress),
    .ramReadData(ramReadData),
    .flush      (flush),
    .outData    (outData),
    .outValid   (outValid),
    .outReady   (outReady),
    .empty      (empty),
`ifdef FIFO_READ_CTRL_STALL_CNT_EN
    .stallCount (stallCount),
`endif
    .level      (level)
  );

  always @(negedge clk) begin
    if (!rst) begin
      assert (tb_pending <= 5'd16)
        else $error("pending out of contract: %0d", tb_pending);
    end
  end

  typedef struct {
    logic        wr;
    logic [31:0] wdata;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [4:0]  exp_rdptr;
    logic [4:0]  exp_level;
    logic        exp_empty;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] d);
    mem[wrPtr[AW-1:0]] = d;
    wrPtr = wrPtr + 1'b1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    wrPtr    = '0;
    flush    = 1'b0;
    outReady = 1'b0;
    for (int k = 0; k < 16; k++) mem[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 32'h11, 1'b0, 1'b1, 32'h11, 5'd1, 5'd1, 1'b0};
    tbl[1] = '{1'b1, 32'h22, 1'b0, 1'b1, 32'h11, 5'd1, 5'd2, 1'b0};
    tbl[2] = '{1'b0, 32'h00, 1'b0, 1'b1, 32'h11, 5'd1, 5'd2, 1'b0};
    tbl[3] = '{1'b0, 32'h00, 1'b0, 1'b1, 32'h11, 5'd1, 5'd2, 1'b0};
    tbl[4] = '{1'b0, 32'h00, 1'b0, 1'b1, 32'h11, 5'd1, 5'd2, 1'b0};
    tbl[5] = '{1'b0, 32'h00, 1'b0, 1'b1, 32'h11, 5'd1, 5'd2, 1'b0};
    tbl[6] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h22, 5'd2, 5'd1, 1'b0};
    tbl[7] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h22, 5'd2, 5'd0, 1'b1};
    tbl[8] = '{1'b1, 32'hA1, 1'b0, 1'b1, 32'hA1, 5'd3, 5'd1, 1'b0};
    tbl[9] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'hA1, 5'd3, 5'd0, 1'b1};

    do_reset();
    chk("reset_valid", 32'(outValid), 32'd0);
    chk("reset_data",  outData,       32'd0);
    chk("reset_rdptr", 32'(rdPtr),    32'd0);
    chk("reset_empty", 32'(empty),    32'd1);
    chk("reset_level", 32'(level),    32'd0);

    // Backpressure then single write/drain
    for (int i = 0; i < 10; i++) begin
      outReady = tbl[i].rdy;
      if (tbl[i].wr) wr(tbl[i].wdata);
      step();
      chk($sformatf("v%0d_valid", i), 32'(outValid), 32'(tbl[i].exp_valid));
      chk($sformatf("v%0d_data", i),  outData,       tbl[i].exp_data);
      chk($sformatf("v%0d_rdptr", i), 32'(rdPtr),    32'(tbl[i].exp_rdptr));
      chk($sformatf("v%0d_level", i), 32'(level),    32'(tbl[i].exp_level));
      chk($sformatf("v%0d_empty", i), 32'(empty),    32'(tbl[i].exp_empty));
`ifdef FIFO_READ_CTRL_STALL_CNT_EN
      if (i == 7) chk("stall_count", stallCount, 32'd5);
`endif
    end

    // Flush with three samples pending behind a held sample
    outReady = 1'b0;
    wr(32'hC0); step();
    wr(32'hC1); step();
    wr(32'hC2); step();
    wr(32'hC3); step();
    chk("pre_flush_valid", 32'(outValid), 32'd1);
    chk("pre_flush_level", 32'(level),    32'd4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_valid", 32'(outValid), 32'd0);
    chk("flush_rdptr", 32'(rdPtr),    32'd7);
    chk("flush_empty", 32'(empty),    32'd1);
    chk("flush_data",  outData,       32'hC0);

    // Flush on the same edge as a write keeps that write
    wr(32'hD0); step();
    wr(32'hD1); step();
    wr(32'hD2); step();
    wr(32'hD3); step();
    flush = 1'b1;
    mem[11] = 32'hD4;
    @(posedge clk);
    wrPtr <= wrPtr + 1'b1;
    #1;
    flush = 1'b0;
    chk("flushwr_valid", 32'(outValid), 32'd0);
    chk("flushwr_rdptr", 32'(rdPtr),    32'd11);
    chk("flushwr_level", 32'(level),    32'd1);
    chk("flushwr_empty", 32'(empty),    32'd0);
    outReady = 1'b1;
    step();
    chk("flushwr_load", outData,       32'hD4);
    chk("flushwr_lv",   32'(outValid), 32'd1);
    step();
    chk("flushwr_drain", 32'(empty), 32'd1);

    // Full FIFO streamed back-to-back
    do_reset();
    for (int k = 0; k < 16; k++) mem[k] = 32'h1000 + 32'(k);
    wrPtr    = 5'h10;
    outReady = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      if (k == 0) chk("fill_level_max", 32'(level), 32'd16);
      chk($sformatf("fill%0d_valid", k), 32'(outValid), 32'd1);
      chk($sformatf("fill%0d_data", k),  outData,       32'h1000 + 32'(k));
      chk($sformatf("fill%0d_rdptr", k), 32'(rdPtr),    32'(k + 1));
    end
    step();
    chk("fill_end_valid", 32'(outValid), 32'd0);
    chk("fill_end_rdptr", 32'(rdPtr),    32'h10);
    chk("fill_end_empty", 32'(empty),    32'd1);

    // Level saturates when RAM is full and a sample is held
    do_reset();
    wr(32'h5A);
    step();
    for (int k = 0; k < 16; k++) wr(32'h200 + 32'(k));
    #1;
    chk("sat_level", 32'(level),   32'd16);
    chk("sat_empty", 32'(empty),   32'd0);
    chk("sat_data",  outData,      32'h5A);

    // Pointer wrap across the end of the RAM
    do_reset();
    wrPtr = 5'h0E;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("wrap_prime_rdptr", 32'(rdPtr), 32'h0E);
    chk("wrap_prime_empty", 32'(empty), 32'd1);
    mem[14] = 32'hE0; mem[15] = 32'hE1; mem[0] = 32'hE2; mem[1] = 32'hE3;
    wrPtr    = 5'h12;
    outReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      automatic logic [3:0] exp_addr = 4'(14 + k);
      chk($sformatf("wrap%0d_addr", k), 32'(ramAddress), 32'(exp_addr));
      step();
      chk($sformatf("wrap%0d_data", k), outData, 32'hE0 + 32'(k));
    end
    chk("wrap_rdptr", 32'(rdPtr), 32'h12);

    // Asynchronous reset while a sample is held
    do_reset();
    wr(32'h77);
    step();
    chk("midrst_pre_valid", 32'(outValid), 32'd1);
    #2;
    rst   = 1'b1;
    wrPtr = '0;
    #1;
    chk("midrst_valid", 32'(outValid), 32'd0);
    chk("midrst_rdptr", 32'(rdPtr),    32'd0);
    chk("midrst_data",  outData,       32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
